// File: rtl/uart_rx_sampler_if.sv
// Receive-side handshake bundle for uart_rx_sampler.
//   rx_data  : received byte, stable while rx_valid=1
//   rx_valid : holding register full
//   rx_ready : consumer accept; a transfer happens on rx_valid & rx_ready
// master = receiver (drives data/valid), slave = consumer (drives ready).
interface uart_rx_sampler_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART receiver with a one-entry holding register.
//   Default frame is 8N1. Defining UART_RX_PARITY_EN switches to 8E1 and enables
//   the parity_err pulse; otherwise parity_err is tied 0.
// Ports:
//   hw_clk     system clock
//   rst        synchronous reset, active-high
//   uartrx     asynchronous serial line, idle high
//   rx_if      master side of uart_rx_sampler_if (rx_data/rx_valid out, rx_ready in)
//   rx_busy    frame in progress
//   frame_err  1-cycle pulse, stop bit sampled low
//   overrun    1-cycle pulse, byte completed while holding register full
//   parity_err 1-cycle pulse, even-parity mismatch (parity build only)
module uart_rx_sampler #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic              hw_clk,
  input  logic              rst,
  input  logic              uartrx,
  uart_rx_sampler_if.master rx_if,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);
  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] OS_HALF  = TW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  // ---------------- input synchroniser ----------------
  logic sync1_q, sync1_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
  logic fall;

  always_comb begin
    sync1_d    = uartrx;
    rxs_d      = sync1_q;
    rxs_prev_d = rxs_q;
  end

  // Reset to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge hw_clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= sync1_d;
      rxs_q      <= rxs_d;
      rxs_prev_q <= rxs_prev_d;
    end
  end

  assign fall = rxs_prev_q & ~rxs_q;

  // ---------------- frame FSM ----------------
  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [TW-1:0] tcnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          deliver_q, frame_err_q;
  logic          tick;
`ifdef UART_RX_PARITY_EN
  logic          par_bit_q;
`endif

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge hw_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      tcnt_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q   <= 1'b0;
`endif
    end else begin
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      // Held at 0 in IDLE, so the tick phase is anchored to the start edge.
      div_q <= (state_q == S_IDLE || tick) ? '0 : div_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (fall) begin
            state_q <= S_START;
            tcnt_q  <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            if (tcnt_q == OS_HALF) begin
              tcnt_q <= '0;
              if (!rxs_q) begin
                state_q <= S_DATA;
                bit_q   <= '0;
              end else begin
                state_q <= S_IDLE;  // glitch, silently dropped
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (tcnt_q == OS_LAST) begin
              tcnt_q  <= '0;
              shift_q <= {rxs_q, shift_q[7:1]};
              bit_q   <= bit_q + 1'b1;
              if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            if (tcnt_q == OS_LAST) begin
              tcnt_q    <= '0;
              par_bit_q <= rxs_q;
              state_q   <= S_STOP;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (tcnt_q == OS_LAST) begin
              tcnt_q <= '0;
              if (rxs_q) begin
                deliver_q <= 1'b1;
                state_q   <= S_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= S_BREAK;
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        S_BREAK: begin
          // A held-low line must go high before another start edge counts.
          if (rxs_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- holding register ----------------
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic       parity_err_q, parity_err_d;

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    overrun_d    = 1'b0;
    parity_err_d = 1'b0;
    if (deliver_q) begin
      // A same-cycle accept frees the slot, so the new byte replaces the old one.
      if (!rx_valid_q || rx_if.rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      parity_err_d = ^{shift_q, par_bit_q};
`endif
    end else if (rx_valid_q && rx_if.rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge hw_clk) begin
    if (rst) begin
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign rx_if.rx_data  = rx_data_q;
  assign rx_if.rx_valid = rx_valid_q;
  assign rx_busy        = (state_q != S_IDLE);
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;
  assign parity_err     = parity_err_q;
endmodule
